// File: rtl/mips_pc_pkg.sv
// mips_pc_pkg
//   Shared definitions for the program-counter unit of the single-cycle
//   MIPS datapath: the run-control state encoding, the sequential PC
//   increment and the default reset vector.
package mips_pc_pkg;

   // Run-control FSM states. The 2-bit encoding is visible on the
   // state_dbg port of next_pc_unit.
   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2,
      ST_FAULT  = 2'd3
   } state_e;

   // Sequential PC step: one 32-bit instruction word.
   localparam int PC_INC = 4;

   // Reset vector used when the top-level RESET_PC parameter is not overridden.
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc
//   Purely combinational candidate-PC generator.
//   Ports:
//     pc            in   current program counter
//     offset_sl2    in   sign-extended immediate, already shifted left by 2
//     instr_index   in   instruction bits [25:0] (j/jal target field)
//     pc_plus4      out  pc + 4 (wraps modulo 2^WIDTH)
//     branch_target out  pc_plus4 + offset_sl2 (wraps modulo 2^WIDTH)
//     jump_target   out  {pc_plus4[top 4 bits], instr_index, 2'b00}
module pc_target_calc
   import mips_pc_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] offset_sl2,
   input  logic [25:0]      instr_index,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] branch_target,
   output logic [WIDTH-1:0] jump_target
);

   always_comb begin
      pc_plus4      = pc + WIDTH'(PC_INC);
      // Offset is already sign-extended to WIDTH, so a negative offset
      // is simply a two's-complement add that wraps.
      branch_target = pc_plus4 + offset_sl2;
      // j/jal stay inside the 256 MB region of the delay-slot address.
      jump_target   = {pc_plus4[WIDTH-1:28], instr_index, 2'b00};
   end

endmodule

// File: rtl/next_pc_unit.sv
// next_pc_unit
//   Program-counter register and next-PC selection with run control.
//   Ports:
//     clk, rst_n        clock (rising edge), async active-low reset
//     stall             hold pc this cycle (all controls ignored)
//     branch_eq/ne,zero beq/bne decode and ALU zero flag
//     jump, jump_reg    j/jal and jr decode
//     rs_data           jr target
//     offset_sl2        word-aligned sign-extended branch offset
//     instr_index       j/jal target field
//     halt              decoded halt
//     pc, pc_plus4      imem address and its +4
//     fetch_valid       pc is a valid fetch address (RUN only)
//     halted            FSM in HALTED
//     misaligned        sticky: a jr target was not word aligned
//     state_dbg         current FSM state
//   Next-PC priority: jump_reg > jump > taken branch > pc_plus4.
//   HALTED and FAULT are terminal; only rst_n leaves them.
module next_pc_unit
   import mips_pc_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             branch_eq,
   input  logic             branch_ne,
   input  logic             zero,
   input  logic             jump,
   input  logic             jump_reg,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] offset_sl2,
   input  logic [25:0]      instr_index,
   input  logic             halt,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             fetch_valid,
   output logic             halted,
   output logic             misaligned,
   output state_e           state_dbg
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             misaligned_q, misaligned_d;

   logic [WIDTH-1:0] branch_target;
   logic [WIDTH-1:0] jump_target;
   logic [WIDTH-1:0] next_pc;
   logic             taken;

   pc_target_calc #(.WIDTH(WIDTH)) u_calc (
      .pc            (pc_q),
      .offset_sl2    (offset_sl2),
      .instr_index   (instr_index),
      .pc_plus4      (pc_plus4),
      .branch_target (branch_target),
      .jump_target   (jump_target)
   );

   always_comb begin
      taken = (branch_eq & zero) | (branch_ne & ~zero);
      if (jump_reg)   next_pc = rs_data;
      else if (jump)  next_pc = jump_target;
      else if (taken) next_pc = branch_target;
      else            next_pc = pc_plus4;
   end

   // Inputs are only looked at in RUN, so X on them elsewhere cannot
   // reach the state.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      misaligned_d = misaligned_q;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (!stall) begin
               if (halt) begin
                  state_d = ST_HALTED;
               end else if (jump_reg && (rs_data[1:0] != 2'b00)) begin
                  // pc stays on the faulting jr for post-mortem.
                  misaligned_d = 1'b1;
                  state_d      = ST_FAULT;
               end else begin
                  pc_d = next_pc;
               end
            end
         end
         default: ; // HALTED / FAULT: frozen until reset
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_BOOT;
         pc_q         <= RESET_PC;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign pc          = pc_q;
   assign fetch_valid = (state_q == ST_RUN);
   assign halted      = (state_q == ST_HALTED);
   assign misaligned  = misaligned_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit
//   Directed bench for next_pc_unit. The driver applies inputs on the
//   falling edge and queues the response expected after the next rising
//   edge; a monitor pops and compares shortly after each rising edge.
module tb_next_pc_unit;
   import mips_pc_pkg::*;

   localparam int W = 32;
   localparam int RW = 2 * W + 5;

   logic          clk;
   logic          rst_n;
   logic          stall, branch_eq, branch_ne, zero, jump, jump_reg, halt;
   logic [W-1:0]  rs_data, offset_sl2;
   logic [25:0]   instr_index;
   logic [W-1:0]  pc, pc_plus4;
   logic          fetch_valid, halted, misaligned;
   state_e        state_dbg;

   logic [RW-1:0] exp_q[$];
   string         name_q[$];
   int            n_pass;
   int            n_total;

   next_pc_unit #(.WIDTH(W), .RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .branch_eq   (branch_eq),
      .branch_ne   (branch_ne),
      .zero        (zero),
      .jump        (jump),
      .jump_reg    (jump_reg),
      .rs_data     (rs_data),
      .offset_sl2  (offset_sl2),
      .instr_index (instr_index),
      .halt        (halt),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .fetch_valid (fetch_valid),
      .halted      (halted),
      .misaligned  (misaligned),
      .state_dbg   (state_dbg)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- expectation builder / compare ----------------
   function automatic logic [RW-1:0] mk_exp(input logic [W-1:0] e_pc,
                                            input state_e e_st,
                                            input logic e_mis);
      logic [W-1:0] e_p4;
      e_p4 = e_pc + 32'd4;
      return {e_pc, e_p4, logic'(e_st), e_st == ST_RUN, e_st == ST_HALTED, e_mis};
   endfunction

   task automatic compare(input logic [RW-1:0] exp_v, input string nm);
      logic [RW-1:0] act_v;
      act_v = {pc, pc_plus4, logic'(state_dbg), fetch_valid, halted, misaligned};
      n_total++;
      if (act_v === exp_v) n_pass++;
      else
         $display("FAIL %s: got pc=%h pc4=%h st=%0d fv=%b hl=%b mis=%b, want pc=%h pc4=%h st=%0d fv=%b hl=%b mis=%b",
                  nm, act_v[RW-1 -: W], act_v[RW-W-1 -: W], act_v[4:3], act_v[2], act_v[1], act_v[0],
                  exp_v[RW-1 -: W], exp_v[RW-W-1 -: W], exp_v[4:3], exp_v[2], exp_v[1], exp_v[0]);
   endtask

   // ---------------- monitor ----------------
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) compare(exp_q.pop_front(), name_q.pop_front());
   end

   // ---------------- driver tasks ----------------
   task automatic idle();
      stall = 0; branch_eq = 0; branch_ne = 0; zero = 0; jump = 0;
      jump_reg = 0; halt = 0; rs_data = '0; offset_sl2 = '0; instr_index = '0;
   endtask

   // Queue expected post-edge response, then advance to the next falling edge.
   task automatic step(input logic [W-1:0] e_pc, input state_e e_st,
                       input logic e_mis, input string nm);
      exp_q.push_back(mk_exp(e_pc, e_st, e_mis));
      name_q.push_back(nm);
      @(posedge clk);
      @(negedge clk);
      idle();
   endtask

   task automatic jr_to(input logic [W-1:0] tgt, input string nm);
      jump_reg = 1; rs_data = tgt;
      step(tgt, ST_RUN, 1'b0, nm);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_pass = 0; n_total = 0;
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      step(32'h0, ST_BOOT, 1'b0, "reset_hold0");
      jump = 1; halt = 1;                      // ignored during reset
      step(32'h0, ST_BOOT, 1'b0, "reset_hold1");

      // Boot: one non-fetching cycle, then sequential fetch.
      rst_n = 1'b1;
      #1 compare(mk_exp(32'h0, ST_BOOT, 1'b0), "boot_cycle");
      stall = 1;                               // BOOT leaves regardless
      step(32'h0, ST_RUN, 1'b0, "boot_to_run");
      step(32'h4, ST_RUN, 1'b0, "seq_4");
      step(32'h8, ST_RUN, 1'b0, "seq_8");
      step(32'hC, ST_RUN, 1'b0, "seq_c");

      // Branches from 0x100.
      jr_to(32'h100, "jr_100_a");
      branch_eq = 1; zero = 1; offset_sl2 = 32'h40;
      step(32'h144, ST_RUN, 1'b0, "beq_taken");
      jr_to(32'h100, "jr_100_b");
      branch_eq = 1; zero = 0; offset_sl2 = 32'h40;
      step(32'h104, ST_RUN, 1'b0, "beq_not_taken");
      jr_to(32'h100, "jr_100_c");
      branch_ne = 1; zero = 0; offset_sl2 = 32'hFFFF_FFF0;
      step(32'hF4, ST_RUN, 1'b0, "bne_neg_offset");

      // Jumps and priority.
      jr_to(32'h0040_0010, "jr_400010");
      jump = 1; instr_index = 26'h000_0100; branch_eq = 1; zero = 1; offset_sl2 = 32'h40;
      step(32'h0000_0400, ST_RUN, 1'b0, "jump_over_branch");
      jr_to(32'hF000_0010, "jr_f0000010");
      jump = 1; instr_index = 26'h000_0100;
      step(32'hF000_0400, ST_RUN, 1'b0, "jump_keeps_region");
      jump = 1; instr_index = 26'h3FF_FFFF; jump_reg = 1; rs_data = 32'h2000;
      step(32'h2000, ST_RUN, 1'b0, "jr_over_jump");

      // Stall, then stall masking halt and a misaligned jr.
      jr_to(32'h20, "jr_20");
      for (int i = 0; i < 3; i++) begin
         stall = 1; jump = 1; instr_index = 26'h123;
         step(32'h20, ST_RUN, 1'b0, $sformatf("stall_%0d", i));
      end
      stall = 1; halt = 1;
      step(32'h20, ST_RUN, 1'b0, "stall_masks_halt");
      stall = 1; jump_reg = 1; rs_data = 32'h1003;
      step(32'h20, ST_RUN, 1'b0, "stall_masks_jr");
      step(32'h24, ST_RUN, 1'b0, "after_stall");

      // Halt beats jump; then terminal for 10 cycles.
      halt = 1; jump = 1; instr_index = 26'h100;
      step(32'h24, ST_HALTED, 1'b0, "halt_enter");
      for (int i = 0; i < 10; i++) begin
         jump = 1; jump_reg = (i % 2 == 0); rs_data = 32'h1002; halt = (i % 3 == 0);
         step(32'h24, ST_HALTED, 1'b0, $sformatf("halted_%0d", i));
      end

      // Fresh boot, then misaligned jr.
      rst_n = 1'b0;
      step(32'h0, ST_BOOT, 1'b0, "reset_from_halt");
      rst_n = 1'b1;
      step(32'h0, ST_RUN, 1'b0, "reboot");
      jr_to(32'h50, "jr_50");
      jump_reg = 1; rs_data = 32'h1002;
      step(32'h50, ST_FAULT, 1'b1, "jr_misaligned");
      jump_reg = 1; rs_data = 32'h100;
      step(32'h50, ST_FAULT, 1'b1, "fault_frozen");

      // Async reset mid-cycle: must take effect without a clock edge.
      #2 rst_n = 1'b0;
      #1 compare(mk_exp(32'h0, ST_BOOT, 1'b0), "async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      step(32'h0, ST_RUN, 1'b0, "boot_after_fault");

      // Wrap-around at the top of the address space.
      jr_to(32'hFFFF_FFFC, "jr_top");
      step(32'h0, ST_RUN, 1'b0, "wrap_to_zero");
      step(32'h4, ST_RUN, 1'b0, "post_wrap");

      repeat (2) @(posedge clk);
      #2;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
